// File: rtl/button_step_debouncer.sv
// Conditions a raw push-button into a debounced level and single-cycle step pulses,
// with optional hold-to-auto-repeat, all on the design clock.
module button_step_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_W         = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic step,
  output logic btn_level,
  output logic rpt_active
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REPEAT,
    REL_DB
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   step_q, step_d;
  logic                   btn_level_q, btn_level_d;
  logic                   rpt_active_q, rpt_active_d;
  logic                   s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
  assign s      = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      step_q       <= 1'b0;
      btn_level_q  <= 1'b0;
      rpt_active_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      btn_level_q  <= btn_level_d;
      rpt_active_q <= rpt_active_d;
    end
  end

  // Every state change clears the counter, so no compare ever sees a wrapped value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s) state_d = PRESS_DB;
      end
      PRESS_DB: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end else if (!repeat_en) begin
          cnt_d = '0;
        end else if (cnt_q == RD_LAST) begin
          state_d = REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!s) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end else if (!repeat_en) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == RP_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL_DB: begin
        // A bounce back to 1 returns to HELD, never REPEAT, so the repeat delay restarts.
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    step_d       = 1'b0;
    btn_level_d  = 1'b0;
    rpt_active_d = 1'b0;
    if ((state_q == PRESS_DB) && (state_d == HELD)) step_d = 1'b1;
    if ((state_q == HELD) && (state_d == REPEAT)) step_d = 1'b1;
    if ((state_q == REPEAT) && (state_d == REPEAT) && (cnt_q == RP_LAST)) step_d = 1'b1;
    if ((state_d == HELD) || (state_d == REPEAT) || (state_d == REL_DB)) btn_level_d = 1'b1;
    if (state_d == REPEAT) rpt_active_d = 1'b1;
  end

  assign step       = step_q;
  assign btn_level  = btn_level_q;
  assign rpt_active = rpt_active_q;

endmodule

// File: doc/button_step_debouncer.md
Name: button_step_debouncer

Overview:
- Upstream conditioning stage for the letter-sequencer display.
- Turns a raw, bouncing push-button input (ui_in pin) into a clean single-cycle `step` pulse that advances the sequencer, plus a debounced level.
- Optional hold-to-auto-repeat emits further `step` pulses while the button is held.
- Runs entirely on the design clock; the sequencer consumes `step` as a synchronous enable instead of clocking on the raw pin.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops on btn_raw; minimum 2.
- DB_CYCLES, 50000: consecutive stable cycles required to accept a press or a release; minimum 2.
- REPEAT_DELAY, 25000000: cycles held in HELD before the first auto-repeat step; minimum 2.
- REPEAT_PERIOD, 5000000: cycles between auto-repeat steps; minimum 2.
- CNT_W, 25: counter width; must hold max(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)-1.

Ports:
- clk  input  1  design clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  1  asynchronous raw button, active high.
- repeat_en  input  1  enables auto-repeat; sampled every cycle.
- step  output  1  one-cycle advance pulse, registered.
- btn_level  output  1  debounced button level, registered.
- rpt_active  output  1  high while in REPEAT state.

Behaviour:
- Reset (rst=1 at a clk edge) sets: synchroniser flops 0, state IDLE, counter 0, step/btn_level/rpt_active 0. Reset overrides all other events.
- s = last synchroniser stage output. The FSM sees only s, never btn_raw.
- FSM states: IDLE, PRESS_DB, HELD, REPEAT, REL_DB. The counter is cleared on every state change.
- IDLE (btn_level=0):
  - s=1: go to PRESS_DB.
- PRESS_DB (btn_level=0):
  - s=0: back to IDLE, no step.
  - counter==DB_CYCLES-1: go to HELD, set btn_level=1, pulse step.
  - else increment the counter.
- HELD (btn_level=1):
  - s=0: go to REL_DB.
  - repeat_en=1 and counter==REPEAT_DELAY-1: go to REPEAT, pulse step.
  - repeat_en=1: increment the counter.
  - repeat_en=0: hold the counter at 0.
- REPEAT (btn_level=1, rpt_active=1):
  - s=0: go to REL_DB.
  - repeat_en=0: go to HELD, no step.
  - counter==REPEAT_PERIOD-1: pulse step, counter to 0.
  - else increment the counter.
- REL_DB (btn_level=1):
  - s=1: go to HELD (never REPEAT), no step; the repeat delay restarts.
  - counter==DB_CYCLES-1: go to IDLE, btn_level=0, no step.
  - else increment the counter.
- Press latency: let E0 be the first clk edge that samples btn_raw=1 after which it stays high. step is high for exactly the one cycle after edge E(SYNC_STAGES+DB_CYCLES), and btn_level rises at the same edge.
- First repeat step occurs REPEAT_DELAY edges after the press step; later repeat steps every REPEAT_PERIOD edges.
- Release latency: SYNC_STAGES+DB_CYCLES edges from the first edge sampling btn_raw=0 until btn_level falls.
- step is never high on two consecutive cycles. No step is ever generated on release.
- Reset mid-operation with the button still held: the hold is treated as a new press, so step is regenerated after the full press latency measured from the first non-reset edge.
- All comparisons are unsigned at CNT_W bits. The counter never wraps, because every compare clears it.

Test Plan:
All scenarios use SYNC_STAGES=2, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, CNT_W=8.
- Clean press, repeat_en=0, btn_raw=1 for 20 cycles then 0 -> one step after E6, btn_level=1 from E6, no further steps; btn_level=0 six edges after the release edge; rpt_active always 0.
- Bounce: btn_raw toggles 1,0 every cycle for 8 cycles then holds 1 -> no step during the bounce; exactly one step 6 edges after the first steady-1 edge.
- Auto-repeat, repeat_en=1, hold 30 cycles -> steps after E6, E16, E19, E22, E25, E28; rpt_active=1 from E16 until release is seen.
- Release glitch in HELD: btn_raw=0 for 2 cycles at E10 -> btn_level stays 1, no step; first repeat step comes 10 edges after the return to HELD, not at E16.
- repeat_en drops to 0 in REPEAT -> next edge goes to HELD, rpt_active=0, no steps; after re-enabling, the first step comes 10 edges later.
- rst pulsed 1 cycle while held in HELD -> step/btn_level/rpt_active=0 at that edge; with btn_raw still 1, a new step 6 edges after the first edge with rst=0.
